// File: rtl/calibration_sequencer.sv
// LED calibration sequencer: walks address bits k, serves the per-LED colour pattern and fires
// one capture step per bit. Optional per-step watchdog enabled by `define CAL_SEQ_TIMEOUT_EN.
module calibration_sequencer #(
  parameter int          NUM_LEDS          = 50,
  parameter int          LED_ADDRESS_WIDTH = 10,
  parameter int          NUM_BITS          = 10,
  parameter int          SETTLE_FRAMES     = 2,
  parameter logic [23:0] COLOR_0           = 24'h00FF00,
  parameter logic [23:0] COLOR_1           = 24'hFF0000,
  parameter logic [23:0] COLOR_IDLE        = 24'h000000,
  parameter int          TIMEOUT_CYCLES    = 50000000,
  localparam int         KW                = $clog2(NUM_BITS + 1)
) (
  input  logic                         clk_pixel,
  input  logic                         rst,
  input  logic                         start_calibration,
  input  logic                         abort,
  input  logic                         led_frame_done,
  input  logic [1:0]                   step_state_in,
  input  logic                         led_req_valid,
  input  logic [LED_ADDRESS_WIDTH-1:0] led_req_index,
  output logic                         start_calibration_step,
  output logic                         should_overwrite_latch,
  output logic [23:0]                  led_color_out,
  output logic                         led_color_valid,
  output logic [KW-1:0]                bit_index,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int LAW = LED_ADDRESS_WIDTH;
  localparam int SW  = $clog2(SETTLE_FRAMES + 1);
  localparam logic [KW-1:0]  LAST_K      = KW'(NUM_BITS - 1);
  localparam logic [SW-1:0]  LAST_SETTLE = SW'(SETTLE_FRAMES - 1);
  localparam logic [LAW:0]   NUM_LEDS_W  = (LAW + 1)'(NUM_LEDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SHOW, ST_FIRE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_DONE
  } state_t;

  state_t        state_r, state_next_s;
  logic [KW-1:0] k_r, k_next_s;
  logic [SW-1:0] settle_r, settle_next_s;
  logic          start_d_r, start_edge_s, start_accept_s, timeout_hit_s, busy_next_s;
  logic          start_step_r, done_r, busy_r, overwrite_r, color_valid_r;
  logic [23:0]   color_r;
  logic [LAW:0]  addr_s, addr_shift_s;

  assign start_edge_s   = start_calibration & ~start_d_r;
  assign start_accept_s = (state_r == ST_IDLE) && start_edge_s && !abort;

  // Next-state logic; abort and watchdog override the normal sequence.
  always_comb begin
    state_next_s  = state_r;
    k_next_s      = k_r;
    settle_next_s = settle_r;
    case (state_r)
      ST_IDLE: begin
        if (start_accept_s) begin
          state_next_s  = ST_SHOW;
          k_next_s      = {KW{1'b0}};
          settle_next_s = {SW{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (led_frame_done) begin
          if (settle_r == LAST_SETTLE) state_next_s = ST_FIRE;
          else settle_next_s = settle_r + SW'(1);
        end else begin
          settle_next_s = settle_r;
        end
      end
      ST_FIRE: state_next_s = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (step_state_in != 2'd0) state_next_s = ST_WAIT_DONE;
        else state_next_s = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (step_state_in == 2'd0) begin
          if (k_r == LAST_K) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s  = ST_SHOW;
            k_next_s      = k_r + KW'(1);
            settle_next_s = {SW{1'b0}};
          end
        end else begin
          state_next_s = ST_WAIT_DONE;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
    if (timeout_hit_s) state_next_s = ST_IDLE;
    else state_next_s = state_next_s;
    if (abort && (state_r != ST_IDLE)) state_next_s = ST_IDLE;
    else state_next_s = state_next_s;
  end

  assign busy_next_s = (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);

  // Sequencer state plus registered control outputs derived from the next state.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      k_r          <= {KW{1'b0}};
      settle_r     <= {SW{1'b0}};
      start_d_r    <= 1'b0;
      start_step_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      overwrite_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      k_r          <= k_next_s;
      settle_r     <= settle_next_s;
      start_d_r    <= start_calibration;
      start_step_r <= (state_next_s == ST_FIRE);
      done_r       <= (state_next_s == ST_DONE);
      busy_r       <= busy_next_s;
      overwrite_r  <= busy_next_s && (k_next_s == {KW{1'b0}});
    end
  end

  // Address 0 is reserved for "no LED", hence the +1 at one extra bit.
  assign addr_s       = {1'b0, led_req_index} + (LAW + 1)'(1);
  assign addr_shift_s = addr_s >> k_r;

  // One-cycle colour lookup pipeline.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      color_r       <= 24'h000000;
      color_valid_r <= 1'b0;
    end else begin
      color_valid_r <= led_req_valid;
      if (!busy_r || ({1'b0, led_req_index} >= NUM_LEDS_W)) color_r <= COLOR_IDLE;
      else if (addr_shift_s[0]) color_r <= COLOR_1;
      else color_r <= COLOR_0;
    end
  end

`ifdef CAL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_r;
  logic          error_r, timed_s;

  assign timed_s       = (state_r == ST_SHOW) || (state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE);
  assign timeout_hit_s = timed_s && (timer_r == TIMER_LAST);

  // Per-state watchdog; error stays set until reset or the next accepted start.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      timer_r <= {TW{1'b0}};
      error_r <= 1'b0;
    end else begin
      if (!timed_s || (state_next_s != state_r)) timer_r <= {TW{1'b0}};
      else timer_r <= timer_r + TW'(1);
      if (timeout_hit_s) error_r <= 1'b1;
      else if (start_accept_s) error_r <= 1'b0;
      else error_r <= error_r;
    end
  end

  assign error = error_r;
`else
  assign timeout_hit_s = 1'b0;
  assign error         = 1'b0;
`endif

  assign start_calibration_step = start_step_r;
  assign should_overwrite_latch = overwrite_r;
  assign led_color_out          = color_r;
  assign led_color_valid        = color_valid_r;
  assign bit_index              = k_r;
  assign busy                   = busy_r;
  assign done                   = done_r;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Self-checking bench for calibration_sequencer: randomized colour requests against a reference
// colour model, scripted step-fsm behaviour, abort, reset and (with CAL_SEQ_TIMEOUT_EN) watchdog.
module tb_calibration_sequencer;

  localparam int NB = 3;
  localparam int NL = 50;
  localparam logic [23:0] C0 = 24'h00FF00;
  localparam logic [23:0] C1 = 24'hFF0000;
  localparam logic [23:0] CI = 24'h000000;

  logic        clk_pixel = 1'b0;
  logic        rst, start_calibration, abort, led_frame_done, led_req_valid;
  logic [1:0]  step_state_in;
  logic [9:0]  led_req_index;
  logic        start_calibration_step, should_overwrite_latch, led_color_valid, busy, done, error;
  logic [23:0] led_color_out;
  logic [1:0]  bit_index;

  int vec_cnt = 0;
  int miscmp_cnt = 0;
  int pulse_cnt = 0;
  int done_cnt = 0;

  always #5 clk_pixel = ~clk_pixel;

  calibration_sequencer #(
    .NUM_LEDS(NL), .LED_ADDRESS_WIDTH(10), .NUM_BITS(NB), .SETTLE_FRAMES(2),
    .COLOR_0(C0), .COLOR_1(C1), .COLOR_IDLE(CI), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_pixel(clk_pixel), .rst(rst), .start_calibration(start_calibration), .abort(abort),
    .led_frame_done(led_frame_done), .step_state_in(step_state_in),
    .led_req_valid(led_req_valid), .led_req_index(led_req_index),
    .start_calibration_step(start_calibration_step), .should_overwrite_latch(should_overwrite_latch),
    .led_color_out(led_color_out), .led_color_valid(led_color_valid), .bit_index(bit_index),
    .busy(busy), .done(done), .error(error)
  );

  always @(negedge clk_pixel) begin
    if (start_calibration_step === 1'b1) pulse_cnt <= pulse_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference colour: LED address is index+1, bit k selects the colour while calibrating.
  function automatic logic [23:0] ref_color(input int idx, input bit active, input int k);
    if (!active || idx >= NL) return CI;
    return ((((idx + 1) >> k) & 1) == 1) ? C1 : C0;
  endfunction

  task automatic tick();
    @(negedge clk_pixel);
  endtask

  task automatic color_window(input int n, input bit active, input int k);
    int  prev_idx;
    bit  prev_v;
    bit  have;
    have = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (have) begin
        check_val("color_valid", {31'd0, led_color_valid}, {31'd0, prev_v});
        if (prev_v) check_val($sformatf("color k=%0d idx=%0d", k, prev_idx), {8'd0, led_color_out},
                              {8'd0, ref_color(prev_idx, active, k)});
      end
      prev_idx      = $urandom_range(0, 63);
      prev_v        = ($urandom_range(0, 3) != 0);
      led_req_index = prev_idx[9:0];
      led_req_valid = prev_v;
      have          = 1'b1;
    end
  endtask

  task automatic pulse_frames_to_fire(input int k);
    int gap;
    tick(); led_frame_done = 1'b1;
    tick(); led_frame_done = 1'b0;
    check_val("no_fire_after_1st_frame", {31'd0, start_calibration_step}, 32'd0);
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      tick();
      check_val("no_fire_in_gap", {31'd0, start_calibration_step}, 32'd0);
    end
    tick(); led_frame_done = 1'b1;
    tick(); led_frame_done = 1'b0;
    check_val("fire_after_2nd_frame", {31'd0, start_calibration_step}, 32'd1);
    check_val("overwrite_at_fire", {31'd0, should_overwrite_latch}, (k == 0) ? 32'd1 : 32'd0);
    check_val("bit_index_at_fire", {30'd0, bit_index}, k);
  endtask

  task automatic do_step(input int k, input bit last, input bit extra_edge);
    int z;
    color_window(5, 1'b1, k);
    if (extra_edge) begin
      start_calibration = 1'b1; tick();
      start_calibration = 1'b0; tick();
    end
    pulse_frames_to_fire(k);
    // Frame pulse during WAIT_BUSY must be ignored.
    tick(); led_frame_done = 1'b1;
    check_val("fire_single_cycle", {31'd0, start_calibration_step}, 32'd0);
    tick(); led_frame_done = 1'b0;
    check_val("no_fire_wait_busy", {31'd0, start_calibration_step}, 32'd0);
    z = $urandom_range(0, 2);
    for (int j = 0; j < z; j++) tick();
    step_state_in = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("busy_during_step", {31'd0, busy}, 32'd1);
      check_val("overwrite_during_step", {31'd0, should_overwrite_latch}, (k == 0) ? 32'd1 : 32'd0);
      led_frame_done = (i == 1);
      step_state_in  = (i == 4) ? 2'd0 : ((i < 1) ? 2'd1 : ((i < 3) ? 2'd2 : 2'd3));
    end
    tick();
    if (last) begin
      check_val("done_pulse", {31'd0, done}, 32'd1);
      check_val("busy_at_done", {31'd0, busy}, 32'd0);
      check_val("bit_index_at_done", {30'd0, bit_index}, k);
    end else begin
      check_val("no_early_done", {31'd0, done}, 32'd0);
      check_val("busy_next_bit", {31'd0, busy}, 32'd1);
      check_val("bit_index_next", {30'd0, bit_index}, k + 1);
      check_val("overwrite_cleared", {31'd0, should_overwrite_latch}, 32'd0);
    end
  endtask

  task automatic run(input bit hold_start, input bit extra_edge);
    int p0, d0;
    p0 = pulse_cnt;
    d0 = done_cnt;
    tick(); start_calibration = 1'b1;
    tick();
    check_val("busy_after_start", {31'd0, busy}, 32'd1);
    check_val("bit_index_start", {30'd0, bit_index}, 32'd0);
    check_val("overwrite_start", {31'd0, should_overwrite_latch}, 32'd1);
    if (!hold_start) start_calibration = 1'b0;
    for (int k = 0; k < NB; k++) do_step(k, k == NB - 1, extra_edge && (k == 1));
    tick();
    check_val("idle_after_done", {31'd0, busy}, 32'd0);
    check_val("done_single_cycle", {31'd0, done}, 32'd0);
    color_window(6, 1'b0, NB - 1);
    check_val("start_pulse_count", pulse_cnt - p0, NB);
    check_val("done_count", done_cnt - d0, 32'd1);
    check_val("bit_index_held", {30'd0, bit_index}, NB - 1);
    if (hold_start) begin
      for (int i = 0; i < 10; i++) tick();
      check_val("held_start_no_rerun", {31'd0, busy}, 32'd0);
      start_calibration = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int p0, d0;
    rst = 1'b1; start_calibration = 1'b0; abort = 1'b0; led_frame_done = 1'b0;
    step_state_in = 2'd0; led_req_valid = 1'b1; led_req_index = 10'd3;
    tick(); tick();
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_fire", {31'd0, start_calibration_step}, 32'd0);
    check_val("rst_overwrite", {31'd0, should_overwrite_latch}, 32'd0);
    check_val("rst_color", {8'd0, led_color_out}, 32'd0);
    check_val("rst_color_valid", {31'd0, led_color_valid}, 32'd0);
    check_val("rst_bit_index", {30'd0, bit_index}, 32'd0);
    check_val("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    tick();
    check_val("idle_color_valid", {31'd0, led_color_valid}, 32'd1);
    check_val("idle_color_idx3", {8'd0, led_color_out}, {8'd0, CI});

    run(1'b0, 1'b0);
    run(1'b1, 1'b0);
    run(1'b0, 1'b1);

    // Abort in WAIT_DONE at k=1, with directed pattern checks at k=1 first.
    p0 = pulse_cnt;
    d0 = done_cnt;
    tick(); start_calibration = 1'b1;
    tick(); start_calibration = 1'b0;
    do_step(0, 1'b0, 1'b0);
    led_req_valid = 1'b1; led_req_index = 10'd0;
    tick(); check_val("k1_idx0", {8'd0, led_color_out}, {8'd0, C0}); led_req_index = 10'd1;
    tick(); check_val("k1_idx1", {8'd0, led_color_out}, {8'd0, C1}); led_req_index = 10'd50;
    tick(); check_val("k1_idx50", {8'd0, led_color_out}, {8'd0, CI});
    pulse_frames_to_fire(1);
    step_state_in = 2'd1;
    tick(); tick();
    check_val("busy_wait_done", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_idle", {31'd0, busy}, 32'd0);
    check_val("abort_overwrite", {31'd0, should_overwrite_latch}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    step_state_in = 2'd0;
    color_window(6, 1'b0, 1);
    check_val("abort_no_done", done_cnt - d0, 32'd0);
    check_val("abort_pulses", pulse_cnt - p0, 32'd2);
    check_val("abort_still_idle", {31'd0, busy}, 32'd0);

    // Abort and start edge together in IDLE: abort wins.
    tick(); start_calibration = 1'b1; abort = 1'b1;
    tick(); abort = 1'b0;
    check_val("abort_beats_start", {31'd0, busy}, 32'd0);
    tick();
    check_val("no_edge_after_abort", {31'd0, busy}, 32'd0);
    start_calibration = 1'b0;

    // Reset mid-run.
    tick(); start_calibration = 1'b1;
    tick(); start_calibration = 1'b0;
    check_val("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check_val("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check_val("midrun_rst_overwrite", {31'd0, should_overwrite_latch}, 32'd0);

`ifdef CAL_SEQ_TIMEOUT_EN
    tick(); start_calibration = 1'b1;
    tick(); start_calibration = 1'b0;
    pulse_frames_to_fire(0);
    step_state_in = 2'd0;
    for (int i = 1; i <= 101; i++) begin
      tick();
      if (i == 100) begin
        check_val("no_timeout_yet", {31'd0, error}, 32'd0);
        check_val("busy_before_timeout", {31'd0, busy}, 32'd1);
      end
      if (i == 101) begin
        check_val("timeout_error", {31'd0, error}, 32'd1);
        check_val("timeout_idle", {31'd0, busy}, 32'd0);
      end
    end
    tick(); tick();
    check_val("error_sticky", {31'd0, error}, 32'd1);
    start_calibration = 1'b1;
    tick(); start_calibration = 1'b0;
    check_val("error_cleared_by_start", {31'd0, error}, 32'd0);
    check_val("busy_after_restart", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check_val("abort_after_restart", {31'd0, busy}, 32'd0);
`else
    check_val("error_tied_low", {31'd0, error}, 32'd0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
